flash_bus_request_ctrl: RTL

- 6809-side front end for the SPI flash engine.
- Synchronizes the 6809 E clock into the clk domain and decodes the flash address window.
- Captures address and write data, then issues one-cycle read/write requests to the downstream SPI flash engine.
- Drives MRDY/HALT and returns read data to the CPU. Replaces the engine's direct E-edge sampling with a clean clk-domain request handshake.

---
 rtl/flash_bus_request_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/flash_bus_request_ctrl.sv
// 6809 bus front end for the SPI flash engine.
// It synchronizes E, decodes the flash window, and issues one-cycle engine requests.
module flash_bus_request_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'hE000,
  parameter logic [15:0] ADDR_MASK = 16'hF000,
  parameter logic [15:0] TIMEOUT   = 16'd4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic [15:0] i_ADDRESS_BUS,
  input  logic [7:0]  i_DataBus,
  input  logic        i_RW,
  output logic        o_req,
  output logic        o_req_rw,
  output logic [23:0] o_req_addr,
  output logic [7:0]  o_req_data,
  input  logic        i_eng_busy,
  input  logic        i_eng_done,
  input  logic [7:0]  i_eng_data,
  output logic [7:0]  o_spi_data,
  output logic        o_MemoryReady,
  output logic        o_HALT,
  output logic        o_timeout_err,
  output logic        o_overrun_err
);

  typedef enum logic [2:0] {
    IDLE, RD_PEND, RD_WAIT, RD_HOLD, WR_PEND
  } state_t;

  state_t      state;
  logic        e_s1, e_s2, e_prev;
  logic [15:0] lat_addr;
  logic        lat_rw, lat_hit;
  logic [15:0] wr_addr;
  logic        rd_after_wr;
  logic [15:0] cnt;

  logic        rise, fall, hit, tmo, rd_hit, wr_fall;
  logic [15:0] pin_off, lat_off;

  assign rise    = e_s2 & ~e_prev;
  assign fall    = ~e_s2 & e_prev;
  assign hit     = (i_ADDRESS_BUS & ADDR_MASK) == BASE_ADDR;
  assign tmo     = cnt == TIMEOUT;
  assign rd_hit  = rise & hit & i_RW;
  assign wr_fall = fall & lat_hit & ~lat_rw;
  assign pin_off = i_ADDRESS_BUS & ~ADDR_MASK;
  assign lat_off = lat_addr & ~ADDR_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      e_s1          <= 1'b0;
      e_s2          <= 1'b0;
      e_prev        <= 1'b0;
      lat_addr      <= '0;
      lat_rw        <= 1'b1;
      lat_hit       <= 1'b0;
      wr_addr       <= '0;
      rd_after_wr   <= 1'b0;
      cnt           <= '0;
      o_req         <= 1'b0;
      o_req_rw      <= 1'b1;
      o_req_addr    <= '0;
      o_req_data    <= '0;
      o_spi_data    <= '0;
      o_MemoryReady <= 1'b1;
      o_HALT        <= 1'b1;
      o_timeout_err <= 1'b0;
      o_overrun_err <= 1'b0;
    end else begin
      e_s1   <= i_enable;
      e_s2   <= e_s1;
      e_prev <= e_s2;
      o_req  <= 1'b0;

      if (rise) begin
        lat_hit <= hit;
        if (hit) begin
          lat_addr <= i_ADDRESS_BUS;
          lat_rw   <= i_RW;
        end
      end

      unique case (state)
        IDLE: begin
          if (rd_hit) begin
            o_MemoryReady <= 1'b0;
            cnt           <= '0;
            if (!i_eng_busy) begin
              o_req      <= 1'b1;
              o_req_rw   <= 1'b1;
              o_req_addr <= {8'h00, pin_off};
              state      <= RD_WAIT;
            end else begin
              o_HALT <= 1'b0;
              state  <= RD_PEND;
            end
          end else if (wr_fall) begin
            o_req_data <= i_DataBus;
            wr_addr    <= lat_off;
            if (!i_eng_busy) begin
              o_req      <= 1'b1;
              o_req_rw   <= 1'b0;
              o_req_addr <= {8'h00, lat_off};
            end else begin
              o_HALT      <= 1'b0;
              rd_after_wr <= 1'b0;
              cnt         <= '0;
              state       <= WR_PEND;
            end
          end
        end

        RD_PEND: begin
          if (!i_eng_busy) begin
            o_req      <= 1'b1;
            o_req_rw   <= 1'b1;
            o_req_addr <= {8'h00, lat_off};
            o_HALT     <= 1'b1;
            cnt        <= '0;
            state      <= RD_WAIT;
          end else if (tmo) begin
            o_MemoryReady <= 1'b1;
            o_HALT        <= 1'b1;
            o_spi_data    <= 8'hFF;
            o_timeout_err <= 1'b1;
            state         <= RD_HOLD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        RD_WAIT: begin
          // done beats a coincident timeout
          if (i_eng_done) begin
            o_spi_data    <= i_eng_data;
            o_MemoryReady <= 1'b1;
            state         <= RD_HOLD;
          end else if (tmo) begin
            o_MemoryReady <= 1'b1;
            o_HALT        <= 1'b1;
            o_spi_data    <= 8'hFF;
            o_timeout_err <= 1'b1;
            state         <= RD_HOLD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        RD_HOLD: begin
          if (fall) state <= IDLE;
        end

        WR_PEND: begin
          if (wr_fall) o_overrun_err <= 1'b1;
          if (rd_hit) begin
            o_MemoryReady <= 1'b0;
            rd_after_wr   <= 1'b1;
          end
          if (!i_eng_busy) begin
            o_req      <= 1'b1;
            o_req_rw   <= 1'b0;
            o_req_addr <= {8'h00, wr_addr};
            o_HALT     <= 1'b1;
            cnt        <= '0;
            state      <= (rd_after_wr || rd_hit) ? RD_PEND : IDLE;
          end else if (tmo) begin
            o_MemoryReady <= 1'b1;
            o_HALT        <= 1'b1;
            o_spi_data    <= 8'hFF;
            o_timeout_err <= 1'b1;
            state         <= (rd_after_wr || rd_hit) ? RD_HOLD : IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
